// File: rtl/gn_mdl_axis_mst_pkt.sv
// AXI4-Stream packet-generating master: counter, PRBS31 or constant payload with tkeep/tlast framing.
// Optional random idle insertion is enabled by defining GN_MDL_AXIS_MST_PKT_THROTTLE_EN.
module gn_mdl_axis_mst_pkt #(
   parameter int P_DWIDTH = 32,
   parameter int P_LEN_W  = 16,
   parameter int P_GAP_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic [P_LEN_W-1:0]    pkt_bytes,
   input  logic [15:0]           pkt_count,
   input  logic [P_GAP_W-1:0]    gap,
   input  logic [31:0]           seed,
   input  logic [3:0]            throttle,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           sent_pkts,
   output logic [P_DWIDTH-1:0]   tx_axis_tdata,
   output logic [P_DWIDTH/8-1:0] tx_axis_tkeep,
   output logic                  tx_axis_tlast,
   output logic                  tx_axis_tvalid,
   input  logic                  tx_axis_tready
);
   localparam int B = P_DWIDTH / 8;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   state_t r_state, w_state_nxt;

   logic [1:0]          r_mode;
   logic [P_LEN_W-1:0]  r_bytes, r_remain, r_k;
   logic [15:0]         r_count, r_sent;
   logic [P_GAP_W-1:0]  r_gap, r_gap_cnt;
   logic [31:0]         r_seed;
   logic [30:0]         r_lfsr;
   logic                r_valid, r_last, r_done;
   logic [P_DWIDTH-1:0] r_data;
   logic [B-1:0]        r_keep;

   logic                w_accept, w_acc_last, w_run_end, w_hold;
   logic                w_start, w_load, w_drop, w_end, w_gap_load, w_is_last;
   logic [15:0]         w_sent_inc;
   logic [30:0]         w_seed31, w_lfsr_nxt;
   logic [P_DWIDTH-1:0] w_prbs, w_const, w_cnt_data, w_data;
   logic [B-1:0]        w_keep;

   assign w_accept   = r_valid & tx_axis_tready;
   assign w_acc_last = w_accept & r_last;
   assign w_sent_inc = r_sent + 16'd1;
   assign w_run_end  = w_acc_last & (((r_count != 16'd0) && (w_sent_inc == r_count)) || stop);
   // An all-zero LFSR state would lock up, so it is replaced by 1.
   assign w_seed31   = (seed[30:0] == 31'd0) ? 31'd1 : seed[30:0];

`ifdef GN_MDL_AXIS_MST_PKT_THROTTLE_EN
   logic [7:0] r_tlfsr;

   always_ff @(posedge clk) begin
      if (reset) r_tlfsr <= 8'hA5;
      else       r_tlfsr <= {r_tlfsr[6:0], r_tlfsr[7] ^ r_tlfsr[5] ^ r_tlfsr[4] ^ r_tlfsr[3]};
   end

   assign w_hold = (r_tlfsr[3:0] < throttle);
`else
   logic w_unused_throttle;
   assign w_unused_throttle = ^throttle;
   assign w_hold = 1'b0;
`endif

   // PRBS31 (x^31 + x^28 + 1): first generated bit lands in tdata[0].
   always_comb begin
      w_lfsr_nxt = r_lfsr;
      w_prbs     = '0;
      for (int i = 0; i < P_DWIDTH; i++) begin
         w_prbs[i]  = w_lfsr_nxt[30] ^ w_lfsr_nxt[27];
         w_lfsr_nxt = {w_lfsr_nxt[29:0], w_prbs[i]};
      end
   end

   always_comb begin
      w_const = '0;
      for (int i = 0; i < P_DWIDTH; i++) w_const[i] = r_seed[i % 32];
   end

   if (P_DWIDTH > P_LEN_W) begin : g_cnt_ext
      assign w_cnt_data = {{(P_DWIDTH-P_LEN_W){1'b0}}, r_k};
   end else begin : g_cnt_trunc
      assign w_cnt_data = r_k[P_DWIDTH-1:0];
   end

   assign w_is_last = (r_remain <= P_LEN_W'(B));

   always_comb begin
      w_keep = '0;
      for (int j = 0; j < B; j++) w_keep[j] = !w_is_last || (P_LEN_W'(j) < r_remain);
      case (r_mode)
         2'd1:    w_data = w_prbs;
         2'd2:    w_data = w_const;
         default: w_data = w_cnt_data;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_drop      = 1'b0;
      w_end       = 1'b0;
      w_gap_load  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && (pkt_bytes != '0)) begin
               w_start     = 1'b1;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            if (w_run_end) begin
               w_state_nxt = IDLE;
               w_end       = 1'b1;
               w_drop      = 1'b1;
            end else if (w_acc_last && (r_gap != '0)) begin
               w_state_nxt = GAP;
               w_drop      = 1'b1;
               w_gap_load  = 1'b1;
            end else if (!r_valid || w_accept) begin
               if (w_hold) w_drop = 1'b1;
               else        w_load = 1'b1;
            end
         end
         GAP: begin
            if (stop) begin
               w_state_nxt = IDLE;
               w_end       = 1'b1;
            end else if (r_gap_cnt <= P_GAP_W'(1)) begin
               w_state_nxt = SEND;
               w_load      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_mode    <= '0;
         r_bytes   <= '0;
         r_remain  <= '0;
         r_k       <= '0;
         r_count   <= '0;
         r_sent    <= '0;
         r_gap     <= '0;
         r_gap_cnt <= '0;
         r_seed    <= '0;
         r_lfsr    <= 31'd1;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_data    <= '0;
         r_keep    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_end;
         if (w_start) begin
            r_mode   <= mode;
            r_bytes  <= pkt_bytes;
            r_remain <= pkt_bytes;
            r_k      <= '0;
            r_count  <= pkt_count;
            r_gap    <= gap;
            r_seed   <= seed;
            r_lfsr   <= w_seed31;
            r_sent   <= '0;
         end
         if (w_acc_last) r_sent <= w_sent_inc;
         if (w_gap_load)            r_gap_cnt <= r_gap;
         else if (r_state == GAP)   r_gap_cnt <= r_gap_cnt - P_GAP_W'(1);
         // Loading a beat also advances the beat index and the PRBS state.
         if (w_load) begin
            r_valid  <= 1'b1;
            r_data   <= w_data;
            r_keep   <= w_keep;
            r_last   <= w_is_last;
            r_lfsr   <= w_lfsr_nxt;
            r_k      <= w_is_last ? '0 : r_k + P_LEN_W'(1);
            r_remain <= w_is_last ? r_bytes : r_remain - P_LEN_W'(B);
         end else if (w_drop) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign sent_pkts      = r_sent;
   assign tx_axis_tdata  = r_data;
   assign tx_axis_tkeep  = r_keep;
   assign tx_axis_tlast  = r_last;
   assign tx_axis_tvalid = r_valid;

endmodule

// File: tb/tb_gn_mdl_axis_mst_pkt.sv
// Directed self-checking bench for gn_mdl_axis_mst_pkt (default parameters, P_DWIDTH=32).
// Compiles with or without GN_MDL_AXIS_MST_PKT_THROTTLE_EN; the throttle test adapts.
`timescale 1ns/1ps
module tb_gn_mdl_axis_mst_pkt;
   localparam int DW = 32;
   localparam int KW = DW / 8;

   logic          clk = 1'b0;
   logic          reset, start, stop;
   logic [1:0]    mode;
   logic [15:0]   pkt_bytes, pkt_count;
   logic [7:0]    gap;
   logic [31:0]   seed;
   logic [3:0]    throttle;
   logic          busy, done;
   logic [15:0]   sent_pkts;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tlast, tvalid, tready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gn_mdl_axis_mst_pkt dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .pkt_bytes(pkt_bytes), .pkt_count(pkt_count), .gap(gap), .seed(seed),
      .throttle(throttle), .busy(busy), .done(done), .sent_pkts(sent_pkts),
      .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tlast(tlast),
      .tx_axis_tvalid(tvalid), .tx_axis_tready(tready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [15:0] nb, input logic [15:0] nc,
                                input logic [7:0] g, input logic [31:0] sd);
      mode = m; pkt_bytes = nb; pkt_count = nc; gap = g; seed = sd;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Reference PRBS31: bit i of the word is the i-th generated bit s[30]^s[27].
   function automatic logic [31:0] prbs_word(input logic [30:0] s_in, output logic [30:0] s_out);
      logic [30:0] s;
      logic [31:0] w;
      s = s_in;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         w[i] = s[30] ^ s[27];
         s = {s[29:0], w[i]};
      end
      s_out = s;
      return w;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b exp 0", tvalid); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b exp 0", tlast); end
      checks++; if (tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata got %h exp 0", tdata); end
      checks++; if (tkeep !== 4'h0) begin errors++; $display("[TB] FAIL reset_tkeep got %h exp 0", tkeep); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
      checks++; if (sent_pkts !== 16'h0) begin errors++; $display("[TB] FAIL reset_sent got %0d exp 0", sent_pkts); end
   endtask

   // 10 bytes -> beats 0,1,2 (tkeep F,F,3), gap of 3 idle cycles, two packets.
   task automatic test_counter();
      bit          ev [12] = '{0,1,1,1,0,0,0,1,1,1,0,0};
      int          ek [12] = '{0,0,1,2,0,0,0,0,1,2,0,0};
      logic [15:0] es [12] = '{0,0,0,0,1,1,1,1,1,1,2,2};
      applyStimulus(2'd0, 16'd10, 16'd2, 8'd3, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++; if (tvalid !== ev[c]) begin errors++; $display("[TB] FAIL cnt_tvalid c=%0d got %b exp %b", c, tvalid, ev[c]); end
         if (ev[c]) begin
            checks++; if (tdata !== 32'(ek[c])) begin errors++; $display("[TB] FAIL cnt_tdata c=%0d got %h exp %h", c, tdata, ek[c]); end
            checks++; if (tkeep !== ((ek[c] == 2) ? 4'h3 : 4'hF)) begin errors++; $display("[TB] FAIL cnt_tkeep c=%0d got %h", c, tkeep); end
            checks++; if (tlast !== (ek[c] == 2)) begin errors++; $display("[TB] FAIL cnt_tlast c=%0d got %b", c, tlast); end
         end
         checks++; if (done !== (c == 10)) begin errors++; $display("[TB] FAIL cnt_done c=%0d got %b exp %b", c, done, (c == 10)); end
         checks++; if (busy !== (c < 10)) begin errors++; $display("[TB] FAIL cnt_busy c=%0d got %b exp %b", c, busy, (c < 10)); end
         checks++; if (sent_pkts !== es[c]) begin errors++; $display("[TB] FAIL cnt_sent c=%0d got %0d exp %0d", c, sent_pkts, es[c]); end
         if (c < 11) tick();
      end
   endtask

   // Seed 0 acts as seed 1; 64 beats over 8 packets with gaps, stream continuous.
   task automatic test_prbs();
      logic [30:0] model;
      logic [31:0] expw;
      int          nb;
      bit          seen;
      model = 31'd1;
      nb    = 0;
      seen  = 1'b0;
      applyStimulus(2'd1, 16'd32, 16'd8, 8'd2, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 0; c < 400 && nb < 64; c++) begin
         @(negedge clk);
         if (tvalid && tready) begin
            expw = prbs_word(model, model);
            checks++; if (tdata !== expw) begin errors++; $display("[TB] FAIL prbs_data beat=%0d got %h exp %h", nb, tdata, expw); end
            checks++; if (tlast !== ((nb % 8) == 7)) begin errors++; $display("[TB] FAIL prbs_tlast beat=%0d got %b", nb, tlast); end
            if (nb == 0) begin
               checks++; if (tdata !== 32'h4800_0000) begin errors++; $display("[TB] FAIL prbs_first got %h exp 48000000", tdata); end
            end
            nb++;
         end
         tick();
      end
      checks++; if (nb != 64) begin errors++; $display("[TB] FAIL prbs_beats got %0d exp 64", nb); end
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            checks++; if (sent_pkts !== 16'd8) begin errors++; $display("[TB] FAIL prbs_sent got %0d exp 8", sent_pkts); end
         end else tick();
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL prbs_done got 0 exp 1"); end
   endtask

   // tready alternates; a stalled beat must hold and no beat may be lost or repeated.
   task automatic test_backpressure();
      int          nb;
      bit          stalled, seen;
      logic [31:0] hd;
      logic [3:0]  hk;
      logic        hl;
      nb = 0; stalled = 1'b0; seen = 1'b0; hd = '0; hk = '0; hl = 1'b0;
      applyStimulus(2'd0, 16'd16, 16'd1, 8'd0, 32'd0);
      tready = 1'b0;
      pulse_start();
      for (int c = 0; c < 40 && !seen; c++) begin
         tready = ((c % 2) == 1);
         @(negedge clk);
         if (stalled) begin
            checks++; if (tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid c=%0d got %b exp 1", c, tvalid); end
            checks++; if ({tdata, tkeep, tlast} !== {hd, hk, hl}) begin errors++; $display("[TB] FAIL bp_hold_beat c=%0d got %h/%h/%b exp %h/%h/%b", c, tdata, tkeep, tlast, hd, hk, hl); end
         end
         if (tvalid && tready) begin
            checks++; if (tdata !== 32'(nb)) begin errors++; $display("[TB] FAIL bp_data beat=%0d got %h exp %h", nb, tdata, nb); end
            checks++; if ({tkeep, tlast} !== {4'hF, (nb == 3)}) begin errors++; $display("[TB] FAIL bp_keep_last beat=%0d got %h/%b", nb, tkeep, tlast); end
            nb++;
         end
         stalled = tvalid && !tready;
         hd = tdata; hk = tkeep; hl = tlast;
         if (done) seen = 1'b1;
         tick();
      end
      checks++; if (nb != 4) begin errors++; $display("[TB] FAIL bp_beats got %0d exp 4", nb); end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_done got 0 exp 1"); end
   endtask

   task automatic test_modes();
      applyStimulus(2'd2, 16'd6, 16'd1, 8'd0, 32'h1234_5678);
      tready = 1'b1;
      pulse_start();
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h1234_5678, 4'hF, 1'b0}) begin errors++; $display("[TB] FAIL const_b0 got %b/%h/%h/%b", tvalid, tdata, tkeep, tlast); end
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h1234_5678, 4'h3, 1'b1}) begin errors++; $display("[TB] FAIL const_b1 got %b/%h/%h/%b", tvalid, tdata, tkeep, tlast); end
      tick(); @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL const_done got %b exp 1", done); end
      applyStimulus(2'd3, 16'd5, 16'd1, 8'd0, 32'hFFFF_FFFF);
      pulse_start();
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h0, 4'hF, 1'b0}) begin errors++; $display("[TB] FAIL mode3_b0 got %b/%h/%h/%b", tvalid, tdata, tkeep, tlast); end
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h1, 4'h1, 1'b1}) begin errors++; $display("[TB] FAIL mode3_b1 got %b/%h/%h/%b", tvalid, tdata, tkeep, tlast); end
      tick(); @(negedge clk);
   endtask

   task automatic test_stop();
      int nb;
      bit seen;
      nb = 0; seen = 1'b0;
      applyStimulus(2'd0, 16'd32, 16'd0, 8'd0, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         if (tvalid && tready) begin
            checks++; if ({tdata, tlast} !== {32'(nb), (nb == 7)}) begin errors++; $display("[TB] FAIL stop_beat n=%0d got %h/%b", nb, tdata, tlast); end
            nb++;
            if (nb == 3) stop = 1'b1;
         end
         if (!seen) tick();
      end
      checks++; if (nb != 8) begin errors++; $display("[TB] FAIL stop_beats got %0d exp 8", nb); end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL stop_done got 0 exp 1"); end
      checks++; if ({busy, sent_pkts} !== {1'b0, 16'd1}) begin errors++; $display("[TB] FAIL stop_end got busy=%b sent=%0d exp 0/1", busy, sent_pkts); end
      stop = 1'b0;
      tick();
      // Stop while in GAP ends the run at the next edge.
      applyStimulus(2'd0, 16'd4, 16'd0, 8'd5, 32'd0);
      pulse_start();
      tick(); @(negedge clk);
      checks++; if ({tvalid, tkeep, tlast} !== {1'b1, 4'hF, 1'b1}) begin errors++; $display("[TB] FAIL gapstop_beat got %b/%h/%b", tvalid, tkeep, tlast); end
      tick(); @(negedge clk);
      checks++; if ({tvalid, busy} !== 2'b01) begin errors++; $display("[TB] FAIL gapstop_in_gap got valid=%b busy=%b exp 0/1", tvalid, busy); end
      stop = 1'b1;
      tick(); @(negedge clk);
      checks++; if ({done, busy, tvalid, sent_pkts} !== {3'b100, 16'd1}) begin errors++; $display("[TB] FAIL gapstop_end got done=%b busy=%b valid=%b sent=%0d", done, busy, tvalid, sent_pkts); end
      stop = 1'b0;
      tick(); @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL gapstop_pulse got %b exp 0", done); end
      // Zero-length start is ignored.
      applyStimulus(2'd0, 16'd0, 16'd1, 8'd0, 32'd0);
      pulse_start();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if ({busy, tvalid, done} !== 3'b000) begin errors++; $display("[TB] FAIL zerolen c=%0d got busy=%b valid=%b done=%b", c, busy, tvalid, done); end
         tick();
      end
   endtask

   // Reset lands on beat 3 of the second packet while stalled.
   task automatic test_reset_mid();
      applyStimulus(2'd0, 16'd16, 16'd0, 8'd0, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 0; c < 8; c++) tick();
      tready = 1'b0;
      @(negedge clk);
      checks++; if ({tvalid, tdata, tlast, sent_pkts} !== {1'b1, 32'd3, 1'b1, 16'd1}) begin errors++; $display("[TB] FAIL rmid_pre got %b/%h/%b/%0d", tvalid, tdata, tlast, sent_pkts); end
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata} !== {1'b1, 32'd3}) begin errors++; $display("[TB] FAIL rmid_stall got %b/%h exp 1/3", tvalid, tdata); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({tvalid, tlast, tdata, tkeep, busy, done, sent_pkts} !== '0) begin errors++; $display("[TB] FAIL rmid_reset got v=%b l=%b d=%h k=%h b=%b dn=%b s=%0d", tvalid, tlast, tdata, tkeep, busy, done, sent_pkts); end
      tready = 1'b1;
      applyStimulus(2'd0, 16'd8, 16'd1, 8'd0, 32'd0);
      pulse_start();
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tlast} !== {1'b1, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL rmid_b0 got %b/%h/%b", tvalid, tdata, tlast); end
      tick(); @(negedge clk);
      checks++; if ({tvalid, tdata, tlast} !== {1'b1, 32'd1, 1'b1}) begin errors++; $display("[TB] FAIL rmid_b1 got %b/%h/%b", tvalid, tdata, tlast); end
      tick(); @(negedge clk);
      checks++; if ({done, sent_pkts} !== {1'b1, 16'd1}) begin errors++; $display("[TB] FAIL rmid_done got %b/%0d exp 1/1", done, sent_pkts); end
   endtask

   task automatic test_throttle();
`ifdef GN_MDL_AXIS_MST_PKT_THROTTLE_EN
      int nb, idles;
      bit seen;
      nb = 0; idles = 0; seen = 1'b0;
      throttle = 4'd15;
      applyStimulus(2'd0, 16'd64, 16'd1, 8'd0, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 0; c < 1500 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (tvalid) begin
            checks++; if (tdata !== 32'(nb)) begin errors++; $display("[TB] FAIL thr_data beat=%0d got %h", nb, tdata); end
            nb++;
         end else if (nb > 0) idles++;
         if (!seen) tick();
      end
      checks++; if (!seen || nb != 16) begin errors++; $display("[TB] FAIL thr_run got beats=%0d done=%b exp 16/1", nb, seen); end
      checks++; if (idles == 0) begin errors++; $display("[TB] FAIL thr_idles got 0 exp >0"); end
      tick();
      throttle = 4'd0;
`else
      throttle = 4'd15;
`endif
      applyStimulus(2'd0, 16'd64, 16'd1, 8'd0, 32'd0);
      tready = 1'b1;
      pulse_start();
      for (int c = 1; c <= 16; c++) begin
         tick(); @(negedge clk);
         checks++; if ({tvalid, tdata} !== {1'b1, 32'(c - 1)}) begin errors++; $display("[TB] FAIL full_rate c=%0d got %b/%h", c, tvalid, tdata); end
      end
      tick(); @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL full_rate_done got %b exp 1", done); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b0; throttle = 4'd0;
      applyStimulus(2'd0, 16'd0, 16'd0, 8'd0, 32'd0);
      test_reset();
      test_counter();
      test_prbs();
      test_backpressure();
      test_modes();
      test_stop();
      test_reset_mid();
      test_throttle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
